// File: rtl/eaglesong_absorb.sv
// Eaglesong sponge absorber: packs message bytes into 256-bit rate blocks, pads, XORs into state, runs an external permutation.
// Latency: one cycle per accepted byte, one PAD cycle, one START cycle, then WAIT until the permutation's ready rises (or TIMEOUT).
// Backpressure: in_ready is high only in IDLE/FILL; absorb_done holds in DONE until done_ack. Word w of a 512-bit bus is bits [32*w +: 32].
module eaglesong_absorb #(
    parameter logic [7:0] DELIMITER = 8'h06,
    parameter int         TIMEOUT   = 255
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [7:0]   in_byte,
    input  logic         in_valid,
    input  logic         in_last,
    output logic         in_ready,
    input  logic         msg_empty,
    output logic [511:0] state_input,
    output logic         start_eval,
    input  logic [511:0] state_output,
    input  logic         eval_output_ready,
    output logic         absorb_done,
    output logic [511:0] absorbed_state,
    input  logic         done_ack,
    output logic [15:0]  block_count,
    output logic         timeout_err
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] FILL  = 3'd1;
    localparam logic [2:0] PAD   = 3'd2;
    localparam logic [2:0] START = 3'd3;
    localparam logic [2:0] WAIT  = 3'd4;
    localparam logic [2:0] DONE  = 3'd5;

    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

    logic [2:0]   fsm;
    logic [511:0] state_q;
    logic [255:0] blk;        // rate block, word w at [32*w +: 32]
    logic [4:0]   idx;        // next byte position within the block
    logic [15:0]  blk_cnt;
    logic [15:0]  wcnt;       // cycles already spent in WAIT
    logic         final_blk;  // current block carries the padding
    logic         pad_pend;   // message ended exactly on a block boundary
    logic         err;
    logic         eor_q;      // eval_output_ready one cycle ago

    // Big-endian byte placement: byte k lands in word k/4, most significant byte first.
    function automatic logic [7:0] byte_lsb(input logic [4:0] k);
        return {k[4:2], 5'b00000} + 8'd24 - {3'b000, k[1:0], 3'b000};
    endfunction

    assign in_ready       = (fsm == IDLE) || (fsm == FILL);
    assign start_eval     = (fsm == START);
    assign absorb_done    = (fsm == DONE);
    assign absorbed_state = state_q;
    assign block_count    = blk_cnt;
    assign timeout_err    = err;
    // State and block are frozen during START/WAIT, so this is stable until WAIT exits.
    assign state_input    = ((fsm == START) || (fsm == WAIT)) ? (state_q ^ {256'b0, blk}) : '0;

    // Previous-cycle copy of the permutation ready, used for rising-edge detection in WAIT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) eor_q <= 1'b0;
        else       eor_q <= eval_output_ready;
    end

    // Absorb FSM with its datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm       <= IDLE;
            state_q   <= '0;
            blk       <= '0;
            idx       <= '0;
            blk_cnt   <= '0;
            wcnt      <= '0;
            final_blk <= 1'b0;
            pad_pend  <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (fsm)
                IDLE: begin
                    state_q   <= '0;
                    blk       <= '0;
                    idx       <= '0;
                    blk_cnt   <= '0;
                    final_blk <= 1'b0;
                    pad_pend  <= 1'b0;
                    if (in_valid) begin
                        // The first byte is taken here since in_ready is already high.
                        blk[31:24] <= in_byte;
                        idx        <= 5'd1;
                        err        <= 1'b0;
                        fsm        <= in_last ? PAD : FILL;
                    end else if (msg_empty) begin
                        err <= 1'b0;
                        fsm <= PAD;
                    end
                end
                FILL: begin
                    if (in_valid) begin
                        blk[byte_lsb(idx) +: 8] <= in_byte;
                        if (idx == 5'd31) begin
                            // Full block goes out first; a last byte here defers the delimiter to a fresh block.
                            idx      <= 5'd0;
                            pad_pend <= in_last;
                            fsm      <= START;
                        end else begin
                            idx <= idx + 5'd1;
                            if (in_last) fsm <= PAD;
                        end
                    end
                end
                PAD: begin
                    for (int k = 0; k < 32; k++) begin
                        if (5'(k) == idx)     blk[byte_lsb(5'(k)) +: 8] <= DELIMITER;
                        else if (5'(k) > idx) blk[byte_lsb(5'(k)) +: 8] <= 8'h00;
                    end
                    final_blk <= 1'b1;
                    fsm       <= START;
                end
                START: begin
                    blk_cnt <= blk_cnt + 16'd1;
                    wcnt    <= '0;
                    fsm     <= WAIT;
                end
                WAIT: begin
                    if (eval_output_ready && !eor_q) begin
                        state_q <= state_output;
                        blk     <= '0;
                        idx     <= '0;
                        if (final_blk) begin
                            fsm <= DONE;
                        end else if (pad_pend) begin
                            pad_pend <= 1'b0;
                            fsm      <= PAD;
                        end else begin
                            fsm <= FILL;
                        end
                    end else if (wcnt == WAIT_LAST) begin
                        err <= 1'b1;
                        fsm <= DONE;
                    end else begin
                        wcnt <= wcnt + 16'd1;
                    end
                end
                DONE: begin
                    if (done_ack) fsm <= IDLE;
                end
                default: fsm <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eaglesong_absorb.sv
// Bench for eaglesong_absorb: a permutation stub answers start_eval; a sponge model predicts every block and final state.
// Latency is not fixed by the stub (random delays); checks are per message plus timeout and reset scenarios.
// Backpressure is exercised by holding bytes while in_ready is low.
module tb_eaglesong_absorb;

    logic         clk = 1'b0;
    logic         reset;
    logic [7:0]   in_byte;
    logic         in_valid, in_last, in_ready, msg_empty;
    logic [511:0] state_input, state_output, absorbed_state;
    logic         start_eval, eval_output_ready, absorb_done, done_ack;
    logic [15:0]  block_count;
    logic         timeout_err;

    int vectors = 0;
    int miscompares = 0;

    int   stub_delay = 0;
    bit   stub_never = 0;
    logic stub_idle_level = 1'b0;

    logic [7:0]   msg_q[$];
    logic [511:0] cap_q[$];
    logic [511:0] exp_q[$];
    logic [511:0] exp_final;

    always #5 clk = ~clk;

    eaglesong_absorb #(.DELIMITER(8'h06), .TIMEOUT(255)) dut (
        .clk(clk), .reset(reset), .in_byte(in_byte), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready), .msg_empty(msg_empty), .state_input(state_input), .start_eval(start_eval),
        .state_output(state_output), .eval_output_ready(eval_output_ready), .absorb_done(absorb_done),
        .absorbed_state(absorbed_state), .done_ack(done_ack), .block_count(block_count),
        .timeout_err(timeout_err)
    );

    // Stand-in permutation: any bijective-looking mix works, it only has to be known to the model.
    function automatic logic [511:0] perm(input logic [511:0] s);
        logic [511:0] r;
        logic [31:0]  w;
        for (int i = 0; i < 16; i++) begin
            w = s[32*((i+1)%16) +: 32];
            r[32*i +: 32] = {w[26:0], w[31:27]} ^ s[32*i +: 32] ^ (32'h9E3779B9 * (i + 1));
        end
        return r;
    endfunction

    // Sponge model: append delimiter, zero-fill to 32-byte blocks, XOR big-endian words into words 0..7.
    task automatic build_model();
        logic [7:0]   p[$];
        logic [511:0] st, si;
        int base;
        p = msg_q;
        p.push_back(8'h06);
        while (p.size() % 32 != 0) p.push_back(8'h00);
        st = '0;
        exp_q.delete();
        for (int b = 0; b < p.size() / 32; b++) begin
            si = st;
            for (int w = 0; w < 8; w++) begin
                base = 32 * b + 4 * w;
                si[32*w +: 32] = si[32*w +: 32] ^ {p[base], p[base+1], p[base+2], p[base+3]};
            end
            exp_q.push_back(si);
            st = perm(si);
        end
        exp_final = st;
    endtask

    // Record every block handed to the permutation.
    initial begin
        forever begin
            @(negedge clk);
            if (start_eval === 1'b1) cap_q.push_back(state_input);
        end
    end

    // Permutation stub: after stub_delay cycles, drop ready, then raise it with the result.
    initial begin
        logic [511:0] c;
        eval_output_ready = 1'b0;
        state_output = '0;
        forever begin
            @(negedge clk);
            if (start_eval === 1'b1 && !stub_never) begin
                c = state_input;
                repeat (stub_delay) @(negedge clk);
                eval_output_ready = 1'b0;
                @(negedge clk);
                state_output = perm(c);
                eval_output_ready = 1'b1;
                @(negedge clk);
            end
            eval_output_ready = stub_idle_level;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1);
    end

    task automatic drive_msg(output bit ok);
        int i = 0;
        int guard = 0;
        if (msg_q.size() == 0) begin
            msg_empty = 1'b1;
            @(negedge clk);
            msg_empty = 1'b0;
            ok = 1'b1;
        end else begin
            while (i < msg_q.size() && guard < 5000) begin
                @(negedge clk);
                guard++;
                in_valid = 1'b1;
                in_byte  = msg_q[i];
                in_last  = (i == msg_q.size() - 1);
                if (in_ready === 1'b1) i++;
            end
            @(negedge clk);
            in_valid = 1'b0;
            in_last  = 1'b0;
            ok = (i == msg_q.size());
        end
    endtask

    task automatic wait_done(output bit ok);
        int n = 0;
        while (absorb_done !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        ok = (absorb_done === 1'b1);
    endtask

    task automatic wait_start();
        int g = 0;
        while (start_eval !== 1'b1 && g < 200) begin
            @(negedge clk);
            g++;
        end
    endtask

    task automatic ack_done();
        done_ack = 1'b1;
        @(negedge clk);
        done_ack = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_byte = 8'h00; in_valid = 1'b0; in_last = 1'b0; msg_empty = 1'b0; done_ack = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if ({in_ready, start_eval, absorb_done, timeout_err} !== 4'b1000) begin
            miscompares++;
            $display("FAIL reset_flags: got rdy/start/done/err=%b required 1000",
                     {in_ready, start_eval, absorb_done, timeout_err});
        end
        vectors++;
        if (block_count !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_block_count: got %0d required 0", block_count);
        end
        vectors++;
        if (state_input !== '0 || absorbed_state !== '0) begin
            miscompares++;
            $display("FAIL reset_state: got state_input=%h absorbed=%h required zero", state_input, absorbed_state);
        end
    endtask

    task automatic test_hello();
        bit ok;
        string s = "Hello, world!\n";
        logic [511:0] e, got;
        msg_q.delete();
        for (int i = 0; i < s.len(); i++) msg_q.push_back(s[i]);
        build_model();
        cap_q.delete();
        stub_delay = 3;
        drive_msg(ok);
        if (ok) wait_done(ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL hello_complete: got %0d required 1", ok); end
        vectors++;
        if (cap_q.size() != 1) begin miscompares++; $display("FAIL hello_pulses: got %0d required 1", cap_q.size()); end
        e = '0;
        e[31:0] = 32'h48656C6C; e[63:32] = 32'h6F2C2077; e[95:64] = 32'h6F726C64; e[127:96] = 32'h210A0600;
        got = (cap_q.size() > 0) ? cap_q[0] : 'x;
        vectors++;
        if (got !== e) begin miscompares++; $display("FAIL hello_block: got %h required %h", got, e); end
        vectors++;
        if (block_count !== 16'd1) begin miscompares++; $display("FAIL hello_count: got %0d required 1", block_count); end
        vectors++;
        if (absorbed_state !== exp_final) begin
            miscompares++; $display("FAIL hello_final: got %h required %h", absorbed_state, exp_final);
        end
        ack_done();
        vectors++;
        if (in_ready !== 1'b1 || absorb_done !== 1'b0) begin
            miscompares++; $display("FAIL hello_ack: got rdy=%b done=%b required rdy=1 done=0", in_ready, absorb_done);
        end
    endtask

    task automatic test_empty();
        bit ok;
        logic [511:0] e, got;
        msg_q.delete();
        build_model();
        cap_q.delete();
        stub_delay = 5;
        drive_msg(ok);
        wait_done(ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL empty_complete: got %0d required 1", ok); end
        e = '0;
        e[31:0] = 32'h06000000;
        got = (cap_q.size() > 0) ? cap_q[0] : 'x;
        vectors++;
        if (cap_q.size() != 1 || got !== e) begin
            miscompares++; $display("FAIL empty_block: pulses=%0d got %h required 1 pulse of %h", cap_q.size(), got, e);
        end
        vectors++;
        if (absorbed_state !== exp_final || block_count !== 16'd1) begin
            miscompares++; $display("FAIL empty_final: got %h/%0d required %h/1", absorbed_state, block_count, exp_final);
        end
        ack_done();
    endtask

    task automatic test_full_block();
        bit ok;
        logic [511:0] e0, e1, got0, got1;
        msg_q.delete();
        for (int i = 0; i < 32; i++) msg_q.push_back(8'hFF);
        cap_q.delete();
        stub_delay = $urandom_range(0, 4);
        drive_msg(ok);
        if (ok) wait_done(ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL full_complete: got %0d required 1", ok); end
        e0 = '0;
        for (int w = 0; w < 8; w++) e0[32*w +: 32] = 32'hFFFFFFFF;
        e1 = perm(e0);
        e1[31:0] = e1[31:0] ^ 32'h06000000;
        got0 = (cap_q.size() > 0) ? cap_q[0] : 'x;
        got1 = (cap_q.size() > 1) ? cap_q[1] : 'x;
        vectors++;
        if (cap_q.size() != 2) begin miscompares++; $display("FAIL full_pulses: got %0d required 2", cap_q.size()); end
        vectors++;
        if (got0 !== e0) begin miscompares++; $display("FAIL full_block0: got %h required %h", got0, e0); end
        vectors++;
        if (got1 !== e1) begin miscompares++; $display("FAIL full_block1: got %h required %h", got1, e1); end
        vectors++;
        if (block_count !== 16'd2 || absorbed_state !== perm(e1)) begin
            miscompares++; $display("FAIL full_final: count=%0d state=%h required 2 / %h", block_count, absorbed_state, perm(e1));
        end
        ack_done();
    endtask

    task automatic test_random();
        bit ok;
        int lens[8] = '{0, 1, 31, 32, 33, 64, 5, 90};
        int bad;
        lens[6] = $urandom_range(2, 30);
        lens[7] = $urandom_range(34, 95);
        for (int m = 0; m < 8; m++) begin
            msg_q.delete();
            for (int i = 0; i < lens[m]; i++) msg_q.push_back(8'($urandom));
            build_model();
            cap_q.delete();
            stub_delay = $urandom_range(0, 6);
            drive_msg(ok);
            if (ok) wait_done(ok);
            vectors++;
            if (!ok || cap_q.size() != exp_q.size()) begin
                miscompares++;
                $display("FAIL rand_blocks len=%0d: done=%0d pulses=%0d required done=1 pulses=%0d",
                         lens[m], ok, cap_q.size(), exp_q.size());
            end
            bad = -1;
            for (int b = 0; b < exp_q.size() && b < cap_q.size(); b++)
                if (bad < 0 && cap_q[b] !== exp_q[b]) bad = b;
            vectors++;
            if (bad >= 0) begin
                miscompares++;
                $display("FAIL rand_state_input len=%0d block %0d: got %h required %h", lens[m], bad, cap_q[bad], exp_q[bad]);
            end
            vectors++;
            if (absorbed_state !== exp_final || block_count !== 16'(exp_q.size())) begin
                miscompares++;
                $display("FAIL rand_final len=%0d: count=%0d required %0d, state=%h required %h",
                         lens[m], block_count, exp_q.size(), absorbed_state, exp_final);
            end
            ack_done();
        end
    endtask

    task automatic test_prehigh();
        bit ok;
        logic [511:0] si;
        stub_idle_level = 1'b1;
        repeat (3) @(negedge clk);
        msg_q.delete();
        for (int i = 0; i < 10; i++) msg_q.push_back(8'($urandom));
        build_model();
        cap_q.delete();
        stub_delay = 45;
        drive_msg(ok);
        wait_start();
        si = state_input;
        repeat (30) @(negedge clk);
        vectors++;
        if (absorb_done !== 1'b0 || state_input !== si) begin
            miscompares++;
            $display("FAIL prehigh_hold: done=%b state_input=%h required done=0 state_input=%h", absorb_done, state_input, si);
        end
        wait_done(ok);
        stub_idle_level = 1'b0;
        vectors++;
        if (!ok || absorbed_state !== exp_final) begin
            miscompares++; $display("FAIL prehigh_final: done=%0d state=%h required 1 / %h", ok, absorbed_state, exp_final);
        end
        ack_done();
    endtask

    task automatic test_timeout();
        bit ok;
        int n;
        stub_never = 1'b1;
        msg_q.delete();
        for (int i = 0; i < 5; i++) msg_q.push_back(8'($urandom));
        drive_msg(ok);
        wait_start();
        n = 0;
        @(negedge clk);
        while (absorb_done !== 1'b1 && n < 1000) begin
            n++;
            @(negedge clk);
        end
        vectors++;
        if (n != 255) begin miscompares++; $display("FAIL timeout_cycles: got %0d required 255", n); end
        vectors++;
        if (timeout_err !== 1'b1 || absorb_done !== 1'b1 || absorbed_state !== '0) begin
            miscompares++;
            $display("FAIL timeout_flags: err=%b done=%b state=%h required err=1 done=1 state zero",
                     timeout_err, absorb_done, absorbed_state);
        end
        ack_done();
        vectors++;
        if (timeout_err !== 1'b1 || in_ready !== 1'b1) begin
            miscompares++; $display("FAIL timeout_sticky: err=%b rdy=%b required 1/1", timeout_err, in_ready);
        end
        stub_never = 1'b0;
        msg_q.delete();
        drive_msg(ok);
        vectors++;
        if (timeout_err !== 1'b0) begin miscompares++; $display("FAIL timeout_clear: got %b required 0", timeout_err); end
        wait_done(ok);
        ack_done();
    endtask

    task automatic test_reset_mid_wait();
        bit ok;
        stub_never = 1'b1;
        msg_q.delete();
        for (int i = 0; i < 20; i++) msg_q.push_back(8'($urandom));
        drive_msg(ok);
        wait_start();
        repeat (10) @(negedge clk);
        reset = 1'b1;
        #1;
        vectors++;
        if ({in_ready, start_eval, absorb_done, timeout_err} !== 4'b1000 || block_count !== 16'd0 ||
            state_input !== '0 || absorbed_state !== '0) begin
            miscompares++;
            $display("FAIL midwait_reset: rdy/start/done/err=%b count=%0d si_zero=%b abs_zero=%b required 1000/0/1/1",
                     {in_ready, start_eval, absorb_done, timeout_err}, block_count, state_input == '0, absorbed_state == '0);
        end
        stub_idle_level = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        stub_idle_level = 1'b0;
        repeat (2) @(negedge clk);
        stub_idle_level = 1'b1;
        repeat (2) @(negedge clk);
        stub_idle_level = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1 || absorb_done !== 1'b0 || block_count !== 16'd0) begin
            miscompares++;
            $display("FAIL idle_ignores_ready: rdy=%b done=%b count=%0d required 1/0/0", in_ready, absorb_done, block_count);
        end
        stub_never = 1'b0;
        msg_q.delete();
        for (int i = 0; i < 40; i++) msg_q.push_back(8'($urandom));
        build_model();
        cap_q.delete();
        stub_delay = 2;
        drive_msg(ok);
        if (ok) wait_done(ok);
        vectors++;
        if (!ok || cap_q.size() != 2 || absorbed_state !== exp_final || block_count !== 16'd2) begin
            miscompares++;
            $display("FAIL after_reset_msg: done=%0d pulses=%0d count=%0d state=%h required 1/2/2 %h",
                     ok, cap_q.size(), block_count, absorbed_state, exp_final);
        end
        ack_done();
    endtask

    initial begin
        test_reset();
        test_hello();
        test_empty();
        test_full_block();
        test_random();
        test_prehigh();
        test_timeout();
        test_reset_mid_wait();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/eaglesong_absorb.md
EAGLESONG_ABSORB -- requirements
Module: eaglesong_absorb

Interface
REQ-001 SHALL have parameter DELIMITER, default 8'h06: padding byte appended after the last message byte.
REQ-002 SHALL have parameter TIMEOUT, default 255: maximum permutation wait, in cycles, before error.
REQ-003 SHALL have port clk  input  1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1: asynchronous, active-high reset.
REQ-005 SHALL have port in_byte  input  8: message byte.
REQ-006 SHALL have port in_valid  input  1: in_byte is valid.
REQ-007 SHALL have port in_last  input  1: qualifies in_valid; this is the final message byte.
REQ-008 SHALL have port in_ready  output  1: block accepts a byte this cycle.
REQ-009 SHALL have port msg_empty  input  1: start a zero-length message; sampled only in IDLE.
REQ-010 SHALL have port state_input  output  16x32: state presented to the downstream permutation.
REQ-011 SHALL have port start_eval  output  1: one-cycle permutation start pulse.
REQ-012 SHALL have port state_output  input  16x32: permuted state returned by the permutation.
REQ-013 SHALL have port eval_output_ready  input  1: permutation result valid.
REQ-014 SHALL have port absorb_done  output  1: absorption complete; absorbed_state is valid.
REQ-015 SHALL have port absorbed_state  output  16x32: final state, equal to the internal state register.
REQ-016 SHALL have port done_ack  input  1: consumer took the result.
REQ-017 SHALL have port block_count  output  16: number of permutations run for the current message.
REQ-018 SHALL have port timeout_err  output  1: sticky error flag.

Function
REQ-019 SHALL implement an FSM with states IDLE, FILL, PAD, START, WAIT, DONE.
REQ-020 SHALL, in IDLE, clear the 16-word state register, the 5-bit byte index and block_count; in_valid moves to FILL, else msg_empty moves to PAD at index 0.
REQ-021 SHALL pack bytes big-endian: byte index k goes to word k/4, bits [31-8*(k%4) -: 8]; block buffer is 8 words (rate 256 bits).
REQ-022 SHALL assert in_ready only in IDLE and FILL; a byte is accepted when in_valid and in_ready are both high.
REQ-023 SHALL, on accepting a byte with in_last=0 at index 31, go to START; with in_last=1 at any index, go to PAD at index+1 (wrapping to 0 at 31 marks the delimiter for a fresh block).
REQ-024 SHALL, in PAD, write DELIMITER at the pad index, zero all later bytes of the block, go to START, and flag the block as final.
REQ-025 SHALL, for a 32-byte-multiple message, first permute the full block, then permute an extra block holding DELIMITER at byte 0 and zeros elsewhere.
REQ-026 SHALL, in START, drive state_input = state XOR {block words 0..7, 8 zero words} (block into words 0..7), pulse start_eval exactly one cycle, increment block_count, and go to WAIT.
REQ-027 SHALL hold state_input stable from START until WAIT exits.
REQ-028 SHALL exit WAIT only on a rising edge of eval_output_ready (previous cycle 0, current 1); a level that is already high on WAIT entry is ignored.
REQ-029 SHALL, on WAIT completion, load the state register from state_output, clear the block buffer and index, and go to DONE if the block was final, else FILL.
REQ-030 SHALL, if WAIT lasts TIMEOUT cycles, set timeout_err and go to DONE with the state unchanged.
REQ-031 SHALL assert absorb_done only in DONE; done_ack in DONE returns the FSM to IDLE on the next edge; done_ack is ignored elsewhere.
REQ-032 SHALL wrap block_count modulo 2^16.
REQ-033 SHALL clear timeout_err only on reset or on the IDLE-to-FILL/PAD transition.

Reset
REQ-034 SHALL, on reset assertion at any time, including mid-WAIT, immediately force state IDLE; all outputs 0 except in_ready=1; state, buffer and counters 0.
REQ-035 SHALL ignore eval_output_ready edges that occur during reset or while in IDLE.

Verification
REQ-036 Bench SHALL drive "Hello, world!\n" (14 bytes) -> one start_eval pulse; state_input words 0..3 = 48656C6C, 6F2C2077, 6F726C64, 210A0600; words 4..15 = 0; block_count=1.
REQ-037 Bench SHALL drive msg_empty -> state_input word0 = 06000000, all other words 0; absorb_done after the stub's ready rise.
REQ-038 Bench SHALL drive 32 bytes of 0xFF -> two permutations; the second block's word0 = permuted word0 XOR 06000000; block_count=2.
REQ-039 Bench SHALL have the stub hold eval_output_ready high before START -> no early exit; exit only on a later rise (a 45-cycle stub delay is acceptable).
REQ-040 Bench SHALL have the stub never respond -> timeout_err=1 and absorb_done=1 after 255 WAIT cycles.
REQ-041 Bench SHALL assert reset mid-WAIT -> IDLE next, outputs zero, in_ready=1; the next message then absorbs correctly.
